// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch (port 0) and load/store (port 1) share one memory port.
// Grant after the sampling edge; ready pulse one edge after mem_ready; one transaction in flight.
// Optional MEM_ARB_ROUND_ROBIN_EN: contested grants alternate; default is fixed priority, port 1 first.
module mem_port_arbiter #(
    parameter int addr_width = 32,
    parameter int data_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [addr_width-1:0] addr0,
    input  logic [data_width-1:0] wdata0,
    output logic                  ready0,
    output logic [data_width-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr1,
    input  logic [data_width-1:0] wdata1,
    output logic                  ready1,
    output logic [data_width-1:0] rdata1,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  owner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    owner_q;
    logic                    last_grant_q;
    logic                    mem_enable_q;
    logic                    mem_we_q;
    logic [addr_width-1:0]   mem_addr_q;
    logic [data_width-1:0]   mem_wdata_q;
    logic                    ready0_q;
    logic                    ready1_q;
    logic [data_width-1:0]   rdata0_q;
    logic [data_width-1:0]   rdata1_q;
    logic                    busy_q;

    logic                    grant_d;
    logic                    we_d;
    logic [addr_width-1:0]   addr_d;
    logic [data_width-1:0]   wdata_d;

    // Winner selection; a lone requester always wins regardless of mode.
    always_comb begin
        grant_d = req1;
        if (req0 && req1) begin
            grant_d = RoundRobin ? ~last_grant_q : 1'b1;
        end
        we_d    = grant_d ? we1    : we0;
        addr_d  = grant_d ? addr1  : addr0;
        wdata_d = grant_d ? wdata1 : wdata0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready0_q <= 1'b0;
                    ready1_q <= 1'b0;
                    if (req0 || req1) begin
                        owner_q      <= grant_d;
                        mem_we_q     <= we_d;
                        mem_addr_q   <= addr_d;
                        mem_wdata_q  <= wdata_d;
                        mem_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    // Latched fields stay put; requester inputs are not looked at here.
                    if (mem_ready) begin
                        mem_enable_q <= 1'b0;
                        last_grant_q <= owner_q;
                        if (owner_q) begin
                            ready1_q <= 1'b1;
                            if (!mem_we_q) begin
                                rdata1_q <= mem_rdata;
                            end
                        end else begin
                            ready0_q <= 1'b1;
                            if (!mem_we_q) begin
                                rdata0_q <= mem_rdata;
                            end
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not sampled here so the owner can drop or replace req.
                    ready0_q <= 1'b0;
                    ready1_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    mem_enable_q <= 1'b0;
                    ready0_q     <= 1'b0;
                    ready1_q     <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign ready0     = ready0_q;
    assign ready1     = ready1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign mem_enable = mem_enable_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign owner      = owner_q;

    a_ready_exclusive: assert property (@(posedge clock) disable iff (reset)
        !(ready0_q && ready1_q));
    a_enable_only_busy: assert property (@(posedge clock) disable iff (reset)
        mem_enable_q == (state_q == BUSY));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of transactions plus hand-built multi-cycle sequences.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ready0, ready1;
    logic [31:0] rdata0, rdata1;
    logic        mem_enable, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        busy, owner;

    always #5 clock = ~clock;

    mem_port_arbiter #(.addr_width(32), .data_width(32)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ready0(ready0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ready1(ready1), .rdata1(rdata1),
        .mem_enable(mem_enable), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .owner(owner)
    );

    typedef struct {
        bit          req0, req1, we0, we1;
        logic [31:0] addr0, addr1, wdata0, wdata1;
        int          lat;
        logic [31:0] mrdata;
        bit          exp_owner;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rd0, rd1;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[7];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_rd0 = '0, m_rd1 = '0;
    bit          m_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Completion monitor: every ready pulse must match the oldest outstanding grant.
    always @(negedge clock) begin
        if (!reset && (ready0 || ready1)) begin
            chk("ready_exclusive", {63'd0, ready0 & ready1}, 64'd0);
            if (sb.size() == 0) begin
                chk("spurious_ready", {62'd0, ready1, ready0}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_port", {63'd0, ready1}, {63'd0, e.port});
                chk("rdata0", {32'd0, rdata0}, {32'd0, e.rd0});
                chk("rdata1", {32'd0, rdata1}, {32'd0, e.rd1});
            end
        end
    end

    task automatic model_grant(input bit port, input bit we, input logic [31:0] rd);
        exp_t e;
        if (!we) begin
            if (port) m_rd1 = rd; else m_rd0 = rd;
        end
        m_last = port;
        e.port = port; e.rd0 = m_rd0; e.rd1 = m_rd1;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_ready = 0; mem_rdata = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_rd0 = '0; m_rd1 = '0; m_last = 1'b0;
        sb.delete();
    endtask

    // One transaction; entered and left on a falling edge.
    task automatic apply(input vec_t v);
        logic [31:0] ea, ew;
        bit          we;
        ea = v.exp_owner ? v.addr1 : v.addr0;
        ew = v.exp_owner ? v.wdata1 : v.wdata0;
        we = v.exp_owner ? v.we1 : v.we0;
        req0 = v.req0; req1 = v.req1; we0 = v.we0; we1 = v.we1;
        addr0 = v.addr0; addr1 = v.addr1; wdata0 = v.wdata0; wdata1 = v.wdata1;
        @(negedge clock);
        chk("grant_enable", {63'd0, mem_enable}, 64'd1);
        chk("grant_owner", {63'd0, owner}, {63'd0, v.exp_owner});
        chk("grant_we", {63'd0, mem_we}, {63'd0, we});
        chk("grant_addr", {32'd0, mem_addr}, {32'd0, ea});
        chk("grant_wdata", {32'd0, mem_wdata}, {32'd0, ew});
        model_grant(v.exp_owner, we, v.mrdata);
        addr0 = ~v.addr0; addr1 = ~v.addr1; wdata0 = $urandom; wdata1 = $urandom;
        repeat (v.lat - 1) @(negedge clock);
        chk("hold_addr", {32'd0, mem_addr}, {32'd0, ea});
        mem_ready = 1'b1; mem_rdata = v.mrdata;
        @(negedge clock);
        mem_ready = 1'b0; mem_rdata = $urandom;
        req0 = 0; req1 = 0;
        chk("done_enable", {63'd0, mem_enable}, 64'd0);
        @(negedge clock);
        chk("ready_seen", sb.size(), 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    // Requests held across n back-to-back loads at mem_ready latency 1.
    task automatic contend(input bit r0, input bit r1, input int n);
        bit eo;
        req0 = r0; req1 = r1; we0 = 0; we1 = 0;
        addr0 = 32'h0040_1000; addr1 = 32'h1001_2000;
        @(negedge clock);
        for (int k = 0; k < n; k++) begin
            eo = (r0 && r1) ? (RR ? ~m_last : 1'b1) : r1;
            chk("b2b_enable", {63'd0, mem_enable}, 64'd1);
            chk("b2b_owner", {63'd0, owner}, {63'd0, eo});
            chk("b2b_addr", {32'd0, mem_addr}, {32'd0, eo ? addr1 : addr0});
            model_grant(eo, 1'b0, 32'h5000_0000 + k);
            mem_ready = 1'b1; mem_rdata = 32'h5000_0000 + k;
            @(negedge clock);
            mem_ready = 1'b0;
            if (k == n - 1) begin req0 = 0; req1 = 0; end
            chk("b2b_drop", {63'd0, mem_enable}, 64'd0);
            @(negedge clock);
            chk("b2b_gap", {63'd0, mem_enable}, 64'd0);
            @(negedge clock);
        end
        chk("no_extra_grant", {63'd0, mem_enable}, 64'd0);
        chk("b2b_all_ready", sb.size(), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1,0,0,0, 32'h0040_0000, 32'h0, 32'h0, 32'h0, 3, 32'h3C01_1001, 0};
        tbl[1] = '{0,1,0,1, 32'h0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1, 32'h1234_5678, 1};
        tbl[2] = '{0,1,0,0, 32'h0, 32'h1001_0008, 32'h0, 32'h0, 2, 32'hAAAA_5555, 1};
        tbl[3] = '{0,1,0,1, 32'h0, 32'h1001_000C, 32'h0, 32'h0102_0304, 4, 32'h7777_0000, 1};
        tbl[4] = '{1,1,0,0, 32'h0040_0004, 32'h1001_0010, 32'h0, 32'h0, 1, 32'h55AA_55AA, !RR};
        tbl[5] = '{1,0,1,0, 32'h0040_0100, 32'h0, 32'h0BAD_F00D, 32'h0, 1, 32'h9999_9999, 0};
        tbl[6] = '{1,1,0,1, 32'h0040_0008, 32'h1001_0014, 32'h0, 32'hCAFE_F00D, 2, 32'h1357_2468, 1};

        do_reset();
        chk("rst_enable", {63'd0, mem_enable}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_owner", {63'd0, owner}, 64'd0);
        chk("rst_ready", {62'd0, ready1, ready0}, 64'd0);
        chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
        chk("rst_rdata", {rdata0, rdata1}, 64'd0);
        chk("rst_we", {63'd0, mem_we}, 64'd0);

        for (int i = 0; i < 7; i++) apply(tbl[i]);

        do_reset();
        contend(1'b1, 1'b1, 4);
        contend(1'b0, 1'b1, 2);

        // Reset two cycles into a fetch abandons it without a ready pulse.
        req0 = 1; addr0 = 32'h0040_0200;
        @(negedge clock);
        chk("rb_enable", {63'd0, mem_enable}, 64'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1; req0 = 0;
        @(negedge clock);
        chk("rb_enable_drop", {63'd0, mem_enable}, 64'd0);
        chk("rb_busy", {63'd0, busy}, 64'd0);
        chk("rb_no_ready", {62'd0, ready1, ready0}, 64'd0);
        reset = 1'b0;
        m_rd0 = '0; m_rd1 = '0; m_last = 1'b0;
        sb.delete();
        @(negedge clock);
        apply(tbl[0]);

        // mem_ready while idle must be ignored.
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000;
        repeat (3) @(negedge clock);
        mem_ready = 1'b0;
        chk("ign_busy", {63'd0, busy}, 64'd0);
        chk("ign_enable", {63'd0, mem_enable}, 64'd0);
        chk("ign_rdata0", {32'd0, rdata0}, {32'd0, m_rd0});
        chk("ign_rdata1", {32'd0, rdata1}, {32'd0, m_rd1});
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
